// File: rtl/trap_seq_pkg.sv
// Shared encodings for the trap sequencer: sysop/cause codes, FSM states and the command record.
// The optional interrupt path is enabled with the TRAP_SEQ_IRQ_EN macro (see trap_seq.sv).
package trap_seq_pkg;

   localparam int XLEN = 64;
   localparam int OPW  = 5;

   localparam logic [3:0] CAUSE_INSN_ILLEGAL = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;
   localparam logic [3:0] IRQ_CAUSE_DEFAULT  = 4'd7;

   // bit4 marks an exception; for non-exception ops the low nibble selects the CSR action
   localparam logic [4:0] SYSOP_NOP     = 5'h00;
   localparam logic [4:0] SYSOP_CSR_W   = 5'h01;
   localparam logic [4:0] SYSOP_CSR_S   = 5'h02;
   localparam logic [4:0] SYSOP_CSR_C   = 5'h03;
   localparam logic [4:0] SYSOP_MRET    = 5'h04;
   localparam logic [4:0] SYSOP_ILLEGAL = {1'b1, CAUSE_INSN_ILLEGAL};
   localparam logic [4:0] SYSOP_EBREAK  = {1'b1, CAUSE_BREAKPOINT};
   localparam logic [4:0] SYSOP_ECALL   = {1'b1, CAUSE_ECALL_M};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } trap_state_e;

   typedef struct packed {
      logic [OPW-1:0]  op;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tval;
      logic [XLEN-1:0] wdata;
   } csr_cmd_t;

   function automatic logic [OPW-1:0] sysop_exc(input logic [3:0] cause);
      return {1'b1, cause};
   endfunction

endpackage

// File: rtl/trap_prio.sv
// Fixed-priority selector: highest set index wins; returns one-hot grant, its index and a valid flag.
module trap_prio #(
   parameter int NSRC = 4,
   parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic [NSRC-1:0] req,
   output logic [NSRC-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            valid
);

   logic found_c;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      found_c = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i] && !found_c) begin
            gnt[i]  = 1'b1;
            idx     = i[IW-1:0];
            found_c = 1'b1;
         end
      end
   end

   assign valid = found_c;

endmodule

// File: rtl/trap_seq.sv
// Trap/sysop sequencer: arbitrates pipeline requesters, issues one CSR command, then flushes on redirect.
// Define TRAP_SEQ_IRQ_EN to add the irq/irq_pc ports and the interrupt issue path.
module trap_seq
   import trap_seq_pkg::*;
#(
   parameter int         NSRC      = 4,
   parameter logic [3:0] IRQ_CAUSE = IRQ_CAUSE_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NSRC-1:0]    src_req,
   input  logic [NSRC*5-1:0]  src_op,
   input  logic [NSRC*64-1:0] src_pc,
   input  logic [NSRC*64-1:0] src_tval,
   input  logic [NSRC*64-1:0] src_wdata,
   output logic [NSRC-1:0]    src_gnt,
   output logic [4:0]         csr_op,
   output logic [63:0]        csr_pc,
   output logic [63:0]        csr_tval,
   output logic [63:0]        csr_wdata,
   input  logic               csr_trap_en,
   input  logic [63:0]        csr_trap_pc,
   output logic               flush,
   output logic [63:0]        redirect_pc,
   output logic               busy
`ifdef TRAP_SEQ_IRQ_EN
   ,
   input  logic               irq,
   input  logic [63:0]        irq_pc
`endif
);

   localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

   csr_cmd_t        src_cmd [NSRC];
   logic [NSRC-1:0] prio_gnt;
   logic [IW-1:0]   prio_idx;
   logic            prio_valid;

   trap_seq_pkg::trap_state_e state_q, state_d;
   csr_cmd_t        cmd_q, cmd_d;
   logic            trap_en_q, trap_en_d;
   logic [63:0]     trap_pc_q, trap_pc_d;
   logic [NSRC-1:0] gnt_c;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_unpack
      assign src_cmd[gi] = '{op:    src_op[gi*5 +: 5],
                             pc:    src_pc[gi*64 +: 64],
                             tval:  src_tval[gi*64 +: 64],
                             wdata: src_wdata[gi*64 +: 64]};
   end

   trap_prio #(.NSRC(NSRC), .IW(IW)) u_prio (
      .req   (src_req),
      .gnt   (prio_gnt),
      .idx   (prio_idx),
      .valid (prio_valid)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      trap_en_d   = trap_en_q;
      trap_pc_d   = trap_pc_q;
      gnt_c       = '0;
      csr_op      = '0;
      csr_pc      = '0;
      csr_tval    = '0;
      csr_wdata   = '0;
      flush       = 1'b0;
      redirect_pc = '0;
      busy        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (prio_valid) begin
               gnt_c     = prio_gnt;
               cmd_d     = src_cmd[prio_idx];
               trap_en_d = 1'b0;
               trap_pc_d = '0;
               state_d   = ST_ISSUE;
            end
`ifdef TRAP_SEQ_IRQ_EN
            // pipeline requests always win; the level irq is taken only when nothing else is pending
            else if (irq) begin
               cmd_d     = '{op: sysop_exc(IRQ_CAUSE), pc: irq_pc, tval: '0, wdata: '0};
               trap_en_d = 1'b0;
               trap_pc_d = '0;
               state_d   = ST_ISSUE;
            end
`endif
         end

         ST_ISSUE: begin
            busy      = 1'b1;
            csr_op    = cmd_q.op;
            csr_pc    = cmd_q.pc;
            csr_tval  = cmd_q.tval;
            csr_wdata = cmd_q.wdata;
            // the CSR unit answers combinationally in the issue cycle
            trap_en_d = csr_trap_en;
            trap_pc_d = csr_trap_pc;
            state_d   = ST_RESP;
         end

         ST_RESP: begin
            busy        = 1'b1;
            flush       = trap_en_q;
            redirect_pc = trap_en_q ? trap_pc_q : '0;
            state_d     = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // grant is combinational from src_req in IDLE, so it must be masked while reset is held
   assign src_gnt = gnt_c & {NSRC{rst_n}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         trap_en_q <= 1'b0;
         trap_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         trap_en_q <= trap_en_d;
         trap_pc_q <= trap_pc_d;
      end
   end

endmodule

// File: tb/tb_trap_seq.sv
// Self-checking bench for trap_seq: table-driven single transactions plus priority, reset and irq sequences.
module tb_trap_seq;
   import trap_seq_pkg::*;

   localparam int NSRC = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NSRC-1:0]    src_req = '0;
   logic [NSRC*5-1:0]  src_op = '0;
   logic [NSRC*64-1:0] src_pc = '0;
   logic [NSRC*64-1:0] src_tval = '0;
   logic [NSRC*64-1:0] src_wdata = '0;
   logic [NSRC-1:0]    src_gnt;
   logic [4:0]         csr_op;
   logic [63:0]        csr_pc, csr_tval, csr_wdata;
   logic               csr_trap_en = 1'b0;
   logic [63:0]        csr_trap_pc = '0;
   logic               flush;
   logic [63:0]        redirect_pc;
   logic               busy;
`ifdef TRAP_SEQ_IRQ_EN
   logic               irq = 1'b0;
   logic [63:0]        irq_pc = '0;
`endif

   always #5 clk = ~clk;

   trap_seq #(.NSRC(NSRC), .IRQ_CAUSE(4'd7)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_req     (src_req),
      .src_op      (src_op),
      .src_pc      (src_pc),
      .src_tval    (src_tval),
      .src_wdata   (src_wdata),
      .src_gnt     (src_gnt),
      .csr_op      (csr_op),
      .csr_pc      (csr_pc),
      .csr_tval    (csr_tval),
      .csr_wdata   (csr_wdata),
      .csr_trap_en (csr_trap_en),
      .csr_trap_pc (csr_trap_pc),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .busy        (busy)
`ifdef TRAP_SEQ_IRQ_EN
      ,
      .irq         (irq),
      .irq_pc      (irq_pc)
`endif
   );

   typedef struct {
      logic [3:0]  req;
      logic [4:0]  op;
      logic [63:0] tval;
      logic        trap_en;
      logic [63:0] trap_pc;
      int          exp_idx;
      logic        exp_flush;
      logic [63:0] exp_redir;
   } vec_t;

   typedef struct {
      logic [4:0]  op;
      logic [63:0] pc;
      logic [63:0] tval;
      logic [63:0] wdata;
      logic        flush;
      logic [63:0] redir;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_val);
      n_tests++;
      if (act !== req_val) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h required %h", name, act, req_val);
      end
   endtask

   function automatic logic [63:0] base_pc(input int i);
      return 64'h8000_0000 + 64'(i) * 64'd16;
   endfunction

   function automatic logic [63:0] base_wdata(input int i);
      return 64'hA5A5_0000 + 64'(i);
   endfunction

   // every source carries distinct default data so a wrong grant shows up on csr_*
   task automatic set_defaults();
      for (int i = 0; i < NSRC; i++) begin
         src_op[i*5 +: 5]      = 5'(5'h08 + i);
         src_pc[i*64 +: 64]    = base_pc(i);
         src_tval[i*64 +: 64]  = 64'h100 + 64'(i);
         src_wdata[i*64 +: 64] = base_wdata(i);
      end
   endtask

   task automatic run_vec(input vec_t v, input int n);
      exp_t e;
      set_defaults();
      src_op[v.exp_idx*5 +: 5]    = v.op;
      src_tval[v.exp_idx*64 +: 64] = v.tval;
      csr_trap_en = v.trap_en;
      csr_trap_pc = v.trap_pc;
      src_req     = v.req;
      sb_q.push_back('{op: v.op, pc: base_pc(v.exp_idx), tval: v.tval,
                       wdata: base_wdata(v.exp_idx), flush: v.exp_flush, redir: v.exp_redir});
      #1;
      check($sformatf("v%0d gnt", n), 64'(src_gnt), 64'd1 << v.exp_idx);
      check($sformatf("v%0d busy_idle", n), 64'(busy), 64'd0);
      @(posedge clk); @(negedge clk);
      src_req[v.exp_idx] = 1'b0;
      if (sb_q.size() == 0) begin
         check($sformatf("v%0d sb_empty", n), 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         check($sformatf("v%0d csr_op", n), 64'(csr_op), 64'(e.op));
         check($sformatf("v%0d csr_pc", n), csr_pc, e.pc);
         check($sformatf("v%0d csr_tval", n), csr_tval, e.tval);
         check($sformatf("v%0d csr_wdata", n), csr_wdata, e.wdata);
         check($sformatf("v%0d busy_issue", n), 64'(busy), 64'd1);
         check($sformatf("v%0d gnt_issue", n), 64'(src_gnt), 64'd0);
         @(posedge clk); @(negedge clk);
         check($sformatf("v%0d flush", n), 64'(flush), 64'(e.flush));
         check($sformatf("v%0d redirect", n), redirect_pc, e.redir);
         check($sformatf("v%0d busy_resp", n), 64'(busy), 64'd1);
         check($sformatf("v%0d gnt_resp", n), 64'(src_gnt), 64'd0);
         check($sformatf("v%0d op_resp", n), 64'(csr_op), 64'd0);
      end
      src_req = '0;
      @(posedge clk); @(negedge clk);
      check($sformatf("v%0d busy_done", n), 64'(busy), 64'd0);
      check($sformatf("v%0d flush_done", n), 64'(flush), 64'd0);
      $display("[TB] vec %0d req=%b idx=%0d op=%h flush=%0b redir=%h",
               n, v.req, v.exp_idx, v.op, v.exp_flush, v.exp_redir);
   endtask

   vec_t vecs[7];

   initial begin
      int          g_cnt;
      int          g_idx[3];
      int          g_cyc[3];
      logic [3:0]  clr;

      vecs[0] = '{4'b0010, 5'h12,       64'h0,   1'b1, 64'h8000_0400, 1, 1'b1, 64'h8000_0400};
      vecs[1] = '{4'b0001, SYSOP_CSR_W, 64'h180, 1'b1, 64'h8000_0004, 0, 1'b1, 64'h8000_0004};
      vecs[2] = '{4'b0001, SYSOP_CSR_W, 64'h300, 1'b0, 64'hDEAD_BEEF, 0, 1'b0, 64'h0};
      vecs[3] = '{4'b0100, SYSOP_NOP,   64'h0,   1'b0, 64'h0,         2, 1'b0, 64'h0};
      vecs[4] = '{4'b1111, SYSOP_ECALL, 64'h0,   1'b1, 64'h8000_0800, 3, 1'b1, 64'h8000_0800};
      vecs[5] = '{4'b0110, SYSOP_EBREAK,64'h0,   1'b1, 64'h8000_0C00, 2, 1'b1, 64'h8000_0C00};
      vecs[6] = '{4'b1000, SYSOP_CSR_S, 64'h341, 1'b0, 64'h1234,      3, 1'b0, 64'h0};

      // reset state with every requester active
      set_defaults();
      src_req = 4'hF;
      #3;
      check("rst gnt", 64'(src_gnt), 64'd0);
      check("rst csr_op", 64'(csr_op), 64'd0);
      check("rst csr_pc", csr_pc, 64'd0);
      check("rst csr_tval", csr_tval, 64'd0);
      check("rst csr_wdata", csr_wdata, 64'd0);
      check("rst flush", 64'(flush), 64'd0);
      check("rst redirect", redirect_pc, 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      src_req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // three held requests: grants 3,1,0 spaced three cycles apart, busy in between
      set_defaults();
      csr_trap_en = 1'b0;
      src_req = 4'b1011;
      g_cnt = 0;
      clr = '0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (src_gnt != 0) begin
            if (g_cnt < 3) begin
               g_cyc[g_cnt] = cyc;
               g_idx[g_cnt] = (src_gnt == 4'b1000) ? 3 : (src_gnt == 4'b0100) ? 2 :
                              (src_gnt == 4'b0010) ? 1 : (src_gnt == 4'b0001) ? 0 : -1;
               $display("[TB] seq1011 grant %0d idx=%0d cycle=%0d", g_cnt, g_idx[g_cnt], cyc);
            end
            g_cnt++;
            clr = src_gnt;
         end else if (g_cnt > 0 && g_cnt < 3) begin
            check($sformatf("seq busy c%0d", cyc), 64'(busy), 64'd1);
         end
         @(posedge clk); @(negedge clk);
         src_req = src_req & ~clr;
         clr = '0;
      end
      check("seq grant count", 64'(g_cnt), 64'd3);
      if (g_cnt >= 3) begin
         check("seq order0", 64'(g_idx[0]), 64'd3);
         check("seq order1", 64'(g_idx[1]), 64'd1);
         check("seq order2", 64'(g_idx[2]), 64'd0);
         check("seq spacing01", 64'(g_cyc[1] - g_cyc[0]), 64'd3);
         check("seq spacing12", 64'(g_cyc[2] - g_cyc[1]), 64'd3);
      end
      src_req = '0;

      // reset pulsed during ISSUE aborts the command; the held request is granted again
      set_defaults();
      csr_trap_en = 1'b1;
      csr_trap_pc = 64'h8000_1234;
      src_req = 4'b0100;
      #1;
      check("rstmid gnt", 64'(src_gnt), 64'h4);
      @(posedge clk); #2;
      check("rstmid issue op", 64'(csr_op), 64'h0A);
      rst_n = 1'b0;
      #1;
      check("rstmid gnt0", 64'(src_gnt), 64'd0);
      check("rstmid op0", 64'(csr_op), 64'd0);
      check("rstmid pc0", csr_pc, 64'd0);
      check("rstmid busy0", 64'(busy), 64'd0);
      check("rstmid flush0", 64'(flush), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      csr_trap_en = 1'b0;
      #1;
      check("rstmid regrant", 64'(src_gnt), 64'h4);
      check("rstmid noflush", 64'(flush), 64'd0);
      @(posedge clk); @(negedge clk);
      src_req = '0;
      check("rstmid reissue op", 64'(csr_op), 64'h0A);
      @(posedge clk); @(negedge clk);
      check("rstmid resp noflush", 64'(flush), 64'd0);
      @(posedge clk); @(negedge clk);
      $display("[TB] reset-during-issue sequence done");

`ifdef TRAP_SEQ_IRQ_EN
      // irq together with source 0: source 0 first, then the interrupt command
      set_defaults();
      csr_trap_en = 1'b0;
      irq = 1'b1;
      irq_pc = 64'h8000_2000;
      src_req = 4'b0001;
      #1;
      check("irq src0 gnt", 64'(src_gnt), 64'h1);
      @(posedge clk); @(negedge clk);
      src_req = '0;
      check("irq src0 op", 64'(csr_op), 64'h08);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      check("irq idle gnt", 64'(src_gnt), 64'd0);
      @(posedge clk); @(negedge clk);
      irq = 1'b0;
      check("irq op", 64'(csr_op), 64'(sysop_exc(4'd7)));
      check("irq pc", csr_pc, 64'h8000_2000);
      check("irq tval", csr_tval, 64'd0);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      $display("[TB] irq sequence done");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
